// File: rtl/pulse_stretch_out_if.sv
// Indicator-pin bundle between system logic and the pulse stretcher.
interface pulse_stretch_out_if #(
  parameter int NCH = 8
);
  logic [NCH-1:0] trig;
  logic [NCH-1:0] hold;
  logic [NCH-1:0] ovf_clr;
  logic [NCH-1:0] out;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] ovf;

  modport master (output trig, hold, ovf_clr, input out, busy, ovf);
  modport slave  (input trig, hold, ovf_clr, output out, busy, ovf);
endinterface

// File: rtl/pulse_stretch_out.sv
// Per-channel pulse stretcher with minimum dark gap, request queueing and sticky overflow.
module pulse_stretch_out_ch #(
  parameter int ON_CYCLES  = 2097152,
  parameter int OFF_CYCLES = 2097152,
  parameter int PEND_W     = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trig_i,
  input  logic hold_i,
  input  logic ovf_clr_i,
  output logic out_o,
  output logic busy_o,
  output logic ovf_o
);
  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0]     ON_LD    = CW'(ON_CYCLES);
  localparam logic [CW-1:0]     OFF_LD   = CW'(OFF_CYCLES);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              out_q, busy_q;

  logic pend_nz, last, take, queue_req, drop;

  assign pend_nz = (pend_q != '0);
  assign last    = (cnt_q == CNT_ONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take      = 1'b0;
    queue_req = trig_i;
    case (state_q)
      IDLE: begin
        // A trig with nothing pending starts the pulse itself instead of queueing.
        queue_req = trig_i && pend_nz;
        if (trig_i || pend_nz) begin
          state_d = ON;
          cnt_d   = ON_LD;
          take    = pend_nz;
        end
      end
      ON: begin
        if (last) begin
          state_d = GAP;
          cnt_d   = OFF_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (last) begin
          if (pend_nz) begin
            state_d = ON;
            cnt_d   = ON_LD;
            take    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    drop   = queue_req && !take && (pend_q == PEND_MAX);
    pend_d = pend_q;
    if (queue_req && !take && !drop) pend_d = pend_q + PEND_ONE;
    else if (!queue_req && take)     pend_d = pend_q - PEND_ONE;

    ovf_d = drop | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      // Registering from next state keeps out/busy aligned with state_q and hold one cycle late.
      out_q   <= (state_d == ON) | hold_i;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign out_o  = out_q;
  assign busy_o = busy_q;
  assign ovf_o  = ovf_q;
endmodule

module pulse_stretch_out #(
  parameter int NCH        = 8,
  parameter int ON_CYCLES  = 2097152,
  parameter int OFF_CYCLES = 2097152,
  parameter int PEND_W     = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  pulse_stretch_out_if.slave bus
);
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pulse_stretch_out_ch #(
      .ON_CYCLES (ON_CYCLES),
      .OFF_CYCLES(OFF_CYCLES),
      .PEND_W    (PEND_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .trig_i   (bus.trig[g]),
      .hold_i   (bus.hold[g]),
      .ovf_clr_i(bus.ovf_clr[g]),
      .out_o    (bus.out[g]),
      .busy_o   (bus.busy[g]),
      .ovf_o    (bus.ovf[g])
    );
  end
endmodule

// File: tb/tb_pulse_stretch_out.sv
// Randomized + directed bench; expected outputs come from a pulse-timeline model via a scoreboard queue.
module tb_pulse_stretch_out;
  localparam int NCH = 2;
  localparam int ONC = 4;
  localparam int OFFC = 3;
  localparam int PEND_W = 2;
  localparam int PMAX = (1 << PEND_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_stretch_out_if #(.NCH(NCH)) bus ();

  pulse_stretch_out #(.NCH(NCH), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .PEND_W(PEND_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  typedef struct packed {
    logic [NCH-1:0] out;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] ovf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int rises = 0;
  logic prev0 = 1'b0;
  int cyc = 0;

  // Model: each channel remembers the cycle its latest pulse went high plus a pending count.
  int   s_m[NCH];
  int   pend_m[NCH];
  logic ovf_m[NCH];

  task automatic drive(input logic [NCH-1:0] tr, input logic [NCH-1:0] ho,
                       input logic [NCH-1:0] cl, input logic r);
    exp_t e;
    @(negedge clk);
    bus.trig = tr; bus.hold = ho; bus.ovf_clr = cl; rst = r;
    for (int c = 0; c < NCH; c++) begin
      if (r) begin
        s_m[c] = -1000; pend_m[c] = 0; ovf_m[c] = 1'b0;
      end else begin
        logic idle, gap_end, take, queued, drop;
        idle    = (cyc >= s_m[c] + ONC + OFFC);
        gap_end = (cyc == s_m[c] + ONC + OFFC - 1);
        take    = 1'b0;
        queued  = tr[c];
        if (idle) begin
          queued = tr[c] && (pend_m[c] > 0);
          if (tr[c] || pend_m[c] > 0) begin
            s_m[c] = cyc + 1;
            take = (pend_m[c] > 0);
          end
        end else if (gap_end && pend_m[c] > 0) begin
          s_m[c] = cyc + 1;
          take = 1'b1;
        end
        drop = queued && !take && (pend_m[c] == PMAX);
        if (queued && !take && !drop) pend_m[c]++;
        else if (!queued && take)     pend_m[c]--;
        ovf_m[c] = drop | (ovf_m[c] & ~cl[c]);
      end
      e.out[c]  = !r && (((cyc + 1 >= s_m[c]) && (cyc + 1 < s_m[c] + ONC)) || ho[c]);
      e.busy[c] = !r && (cyc + 1 >= s_m[c]) && (cyc + 1 < s_m[c] + ONC + OFFC);
      e.ovf[c]  = ovf_m[c];
    end
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.out[0] && !prev0) rises++;
    prev0 = bus.out[0];
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.out !== e.out) begin
        errors++; $display("FAIL out t=%0t got %b exp %b", $time, bus.out, e.out);
      end
      checks++;
      if (bus.busy !== e.busy) begin
        errors++; $display("FAIL busy t=%0t got %b exp %b", $time, bus.busy, e.busy);
      end
      checks++;
      if (bus.ovf !== e.ovf) begin
        errors++; $display("FAIL ovf t=%0t got %b exp %b", $time, bus.ovf, e.ovf);
      end
    end
  end

  initial begin
    bus.trig = '0; bus.hold = '0; bus.ovf_clr = '0;
    for (int c = 0; c < NCH; c++) begin s_m[c] = -1000; pend_m[c] = 0; ovf_m[c] = 1'b0; end
    for (int i = 0; i < 3; i++) drive('0, '0, '0, 1'b1);
    // single pulse
    idle_n(5); drive(2'b01, '0, '0, 1'b0); idle_n(12);
    // two requests, second queued
    drive(2'b01, '0, '0, 1'b0); idle_n(1); drive(2'b01, '0, '0, 1'b0); idle_n(20);
    // saturating burst: exactly four pulses expected
    rises = 0;
    for (int i = 0; i < 6; i++) drive(2'b01, '0, '0, 1'b0);
    idle_n(40);
    checks++;
    if (rises != 4) begin
      errors++; $display("FAIL burst_pulses got %0d exp 4", rises);
    end
    drive('0, '0, 2'b01, 1'b0); idle_n(3);
    // reset mid-pulse
    drive(2'b01, '0, '0, 1'b0); idle_n(1); drive('0, '0, '0, 1'b1); idle_n(15);
    // hold passthrough overlapping a pulse
    for (int i = 0; i < 21; i++) drive((i == 5) ? 2'b10 : 2'b00, 2'b10, '0, 1'b0);
    idle_n(12);
    // both channels together, saturate ch0, then set and clear in the same cycle
    drive(2'b11, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) drive(2'b01, '0, '0, 1'b0);
    drive(2'b01, '0, '0, 1'b0);
    drive(2'b01, '0, 2'b11, 1'b0);
    idle_n(2);
    drive('0, '0, 2'b01, 1'b0);
    idle_n(30);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [NCH-1:0] tr, ho, cl;
      for (int c = 0; c < NCH; c++) begin
        tr[c] = ($urandom_range(7) == 0);
        ho[c] = ($urandom_range(15) == 0);
        cl[c] = ($urandom_range(15) == 0);
      end
      drive(tr, ho, cl, ($urandom_range(499) == 0));
    end
    idle_n(12);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL drain got %0d exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
